axi_lite_mem_slave: RTL and testbench

Parametrised AXI4-Lite memory slave, the next generation of the fixed 12-bit-address / 8-bit-data slave.
- Adds configurable data width with byte strobes, configurable depth and base address, and SLVERR for out-of-range accesses.
- Adds independent read and write engines and programmable read wait states.
- Sits behind the AXI4-Lite interconnect as a leaf target; the monitor and scoreboard observe its ports.

---
 rtl/axi_lite_mem_slave_pkg.sv | 24 ++
 rtl/axi_lite_strb_ram.sv | 34 +++
 rtl/axi_lite_mem_slave.sv | 215 +++++++++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_mem_slave_pkg.sv
// rtl/axi_lite_mem_slave_pkg.sv - shared types and constants for the AXI4-Lite memory slave
package axi_lite_mem_slave_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  localparam int MAX_READ_WAIT = 15;

endpackage

// File: rtl/axi_lite_strb_ram.sv
// rtl/axi_lite_strb_ram.sv - byte-enabled single-write, single-read synchronous RAM
module axi_lite_strb_ram
  import axi_lite_mem_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 512,
  parameter int IDX_W      = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read and write share an edge; the read sees the value from before that edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (we && wstrb[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - parametrised AXI4-Lite memory slave with independent read/write engines
module axi_lite_mem_slave
  import axi_lite_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 512,
  parameter int BASE_ADDR  = 0,
  parameter int READ_WAIT  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int LANE_BITS = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [3:0]            WAIT_INIT = 4'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);

  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_A) >> LANE_BITS;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_A) && (32'(word_of(a)) < 32'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(word_of(a));
  endfunction

  // ---------------- write engine ----------------
  wr_state_t             w_state, w_state_n;
  logic                  aw_held, aw_held_n, w_held, w_held_n;
  logic                  bvalid_n;
  resp_t                 bresp_n;
  logic [ADDR_WIDTH-1:0] awaddr_q, wr_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data;
  logic [STRB_WIDTH-1:0] wstrb_q, wr_strb;
  logic                  aw_fire, w_fire, commit, wr_ok;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  // A beat captured earlier lives in the _q registers; otherwise use the live bus.
  assign wr_addr = aw_held ? awaddr_q : awaddr;
  assign wr_data = w_held ? wdata_q : wdata;
  assign wr_strb = w_held ? wstrb_q : wstrb;
  assign commit  = (w_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
  assign wr_ok   = addr_ok(wr_addr);

  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    case (w_state)
      W_IDLE: begin
        if (commit) begin
          w_state_n = W_RESP;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
          if (aw_fire) aw_held_n = 1'b1;
          if (w_fire)  w_held_n  = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_n = W_IDLE;
          bvalid_n  = 1'b0;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      awready <= 1'b0;
      wready  <= 1'b0;
    end else begin
      w_state <= w_state_n;
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
      awready <= (w_state_n == W_IDLE) & ~aw_held_n;
      wready  <= (w_state_n == W_IDLE) & ~w_held_n;
    end
    if (aw_fire) awaddr_q <= awaddr;
    if (w_fire) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // ---------------- read engine ----------------
  rd_state_t             r_state, r_state_n;
  logic [3:0]            wait_cnt, wait_cnt_n;
  logic [ADDR_WIDTH-1:0] araddr_q, rd_addr;
  logic                  ar_fire, rd_sample, rd_hit, rd_hit_q, rd_hit_n, rvalid_n;
  resp_t                 rresp_n;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign ar_fire = arvalid & arready;
  assign rd_addr = (r_state == R_IDLE) ? araddr : araddr_q;
  assign rd_hit  = addr_ok(rd_addr);

  always_comb begin
    r_state_n  = r_state;
    wait_cnt_n = wait_cnt;
    rvalid_n   = rvalid;
    rresp_n    = rresp;
    rd_hit_n   = rd_hit_q;
    rd_sample  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_fire) begin
          if (READ_WAIT == 0) begin
            r_state_n = R_DATA;
            rd_sample = 1'b1;
          end else begin
            r_state_n  = R_WAIT;
            wait_cnt_n = WAIT_INIT;
          end
        end
      end
      R_WAIT: begin
        if (wait_cnt == 4'd0) begin
          r_state_n = R_DATA;
          rd_sample = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt - 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
    if (rd_sample) begin
      rvalid_n = 1'b1;
      rresp_n  = rd_hit ? RESP_OKAY : RESP_SLVERR;
      rd_hit_n = rd_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= R_IDLE;
      wait_cnt <= 4'd0;
      rvalid   <= 1'b0;
      rresp    <= RESP_OKAY;
      rd_hit_q <= 1'b0;
      arready  <= 1'b0;
    end else begin
      r_state  <= r_state_n;
      wait_cnt <= wait_cnt_n;
      rvalid   <= rvalid_n;
      rresp    <= rresp_n;
      rd_hit_q <= rd_hit_n;
      arready  <= (r_state_n == R_IDLE);
    end
    if (ar_fire) araddr_q <= araddr;
  end

  // Out-of-range reads and the reset state both present zero data.
  assign rdata = rd_hit_q ? ram_rdata : '0;

  axi_lite_strb_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (commit & wr_ok & ~reset),
    .waddr (idx_of(wr_addr)),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .re    (rd_sample & rd_hit),
    .raddr (idx_of(rd_addr)),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb/tb_axi_lite_mem_slave.sv - directed self-checking bench for axi_lite_mem_slave
module tb_axi_lite_mem_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] awaddr = '0, araddr = '0, araddr3 = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0, arvalid3 = 1'b0, rready3 = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        awready3, wready3, bvalid3, arready3, rvalid3;
  logic [1:0]  bresp3, rresp3;
  logic [31:0] rdata3;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_mem_slave #(.READ_WAIT(0)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // Second instance shares the write channel, so its memory mirrors dut's.
  axi_lite_mem_slave #(.READ_WAIT(3)) dut3 (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready3),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready3),
    .bresp(bresp3), .bvalid(bvalid3), .bready(bready),
    .araddr(araddr3), .arvalid(arvalid3), .arready(arready3),
    .rdata(rdata3), .rresp(rresp3), .rvalid(rvalid3), .rready(rready3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int t = 0, n = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && t < 50) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(negedge clk);
      if (aw_f) aw_done = 1;
      if (w_f)  w_done = 1;
      t++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake", {62'd0, aw_done, w_done}, 64'd3);
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid_seen", bvalid, 1);
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r,
                         output int lat);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arready_seen", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, rr;
    logic [31:0] rd;
    int          lat;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resp", {bresp, rresp}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);

    // 1: AW two cycles before W
    do_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 2, resp);
    chk("t1_bresp", resp, 2'b00);
    do_read(12'h010, rd, rr, lat);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_rresp", rr, 2'b00);
    chk("t1_latency", lat, 1);

    // 2: W before AW, then same-beat partial-strobe write
    do_write(12'h010, 32'hDEADBEEF, 4'hF, 2, 0, resp);
    chk("t2a_bresp", resp, 2'b00);
    do_write(12'h010, 32'h11223344, 4'b0101, 0, 0, resp);
    chk("t2b_bresp", resp, 2'b00);
    do_read(12'h010, rd, rr, lat);
    chk("t2_rdata", rd, 32'hDE22BE44);
    do_read(12'h013, rd, rr, lat);
    chk("t2_unaligned", rd, 32'hDE22BE44);

    // wstrb=0 leaves memory unchanged
    do_write(12'h010, 32'hFFFFFFFF, 4'h0, 0, 0, resp);
    chk("strb0_bresp", resp, 2'b00);
    do_read(12'h010, rd, rr, lat);
    chk("strb0_rdata", rd, 32'hDE22BE44);

    // 3: out-of-range accesses; 0x900 aliases word 64 (0x100) if range gating is missing
    do_write(12'h100, 32'h0BADF00D, 4'hF, 0, 0, resp);
    do_read(12'h800, rd, rr, lat);
    chk("t3_oor_rresp", rr, 2'b10);
    chk("t3_oor_rdata", rd, 32'h0);
    do_write(12'h900, 32'hFFFFFFFF, 4'hF, 1, 0, resp);
    chk("t3_oor_bresp", resp, 2'b10);
    do_read(12'h100, rd, rr, lat);
    chk("t3_no_change", rd, 32'h0BADF00D);
    do_write(12'h7FC, 32'h5A5A5A5A, 4'hF, 0, 0, resp);
    chk("t3_top_bresp", resp, 2'b00);
    do_read(12'h7FC, rd, rr, lat);
    chk("t3_top_rdata", rd, 32'h5A5A5A5A);
    chk("t3_top_rresp", rr, 2'b00);

    // 4: READ_WAIT=3 instance, latency and back-pressure stability
    araddr3 = 12'h010; arvalid3 = 1'b1;
    chk("t4_arready", arready3, 1);
    @(negedge clk);
    arvalid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_wait_rvalid", rvalid3, 0);
      chk("t4_wait_arready", arready3, 0);
      @(negedge clk);
    end
    chk("t4_rvalid_n4", rvalid3, 1);
    chk("t4_rdata", rdata3, 32'hDE22BE44);
    chk("t4_rresp", rresp3, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_rvalid", rvalid3, 1);
      chk("t4_hold_rdata", rdata3, 32'hDE22BE44);
      chk("t4_hold_arready", arready3, 0);
    end
    rready3 = 1'b1;
    @(negedge clk);
    rready3 = 1'b0;
    chk("t4_done_rvalid", rvalid3, 0);
    chk("t4_done_arready", arready3, 1);

    // 5: same-cycle write commit and read sample
    do_write(12'h020, 32'hAAAA5555, 4'hF, 0, 0, resp);
    awaddr = 12'h020; wdata = 32'h12345678; wstrb = 4'hF; araddr = 12'h020;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    chk("t5_ready", {awready, wready, arready}, 3'b111);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t5_bvalid", bvalid, 1);
    chk("t5_rvalid", rvalid, 1);
    chk("t5_old_data", rdata, 32'hAAAA5555);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    do_read(12'h020, rd, rr, lat);
    chk("t5_new_data", rd, 32'h12345678);

    // 6: reset with both responses pending
    awaddr = 12'h030; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 12'h010;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t6_pre_bvalid", bvalid, 1);
    chk("t6_pre_rvalid", rvalid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_bvalid", bvalid, 0);
    chk("t6_rvalid", rvalid, 0);
    chk("t6_ready", {awready, wready, arready}, 3'b000);
    chk("t6_rdata", rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_post_ready", {awready, wready, arready}, 3'b111);
    do_read(12'h030, rd, rr, lat);
    chk("t6_committed", rd, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
